// File: rtl/ast_adc_seq.sv
// Conversion sequencer for the AST ADC: power-up settling, one-hot channel select,
// result capture with timeout, valid/ready response channel and optional idle power-down.
module ast_adc_seq #(
  parameter int unsigned AdcChannels  = 2,
  parameter int unsigned AdcDataWidth = 10,
  parameter int unsigned PwrUpCyc     = 8,
  parameter int unsigned TimeoutCyc   = 64,
  parameter int unsigned PdDlyCyc     = 16,
  localparam int unsigned ChanW       = $clog2(AdcChannels) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ChanW-1:0]        req_chan_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [AdcDataWidth-1:0] rsp_data_o,
  output logic [ChanW-1:0]        rsp_chan_o,
  output logic                    rsp_err_o,
  input  logic                    lp_en_i,
  output logic                    adc_pd_o,
  output logic [AdcChannels-1:0]  adc_chn_sel_o,
  input  logic [AdcDataWidth-1:0] adc_data_i,
  input  logic                    adc_data_valid_i,
  output logic                    busy_o,
  output logic [7:0]              timeout_cnt_o
);

  localparam int unsigned PwrW  = $clog2(PwrUpCyc + 1);
  localparam int unsigned TmoW  = $clog2(TimeoutCyc + 1);
  localparam int unsigned IdleW = $clog2(PdDlyCyc + 1);

  typedef enum logic [2:0] {
    StPd    = 3'd0,
    StPwrUp = 3'd1,
    StIdle  = 3'd2,
    StConv  = 3'd3,
    StResp  = 3'd4
  } state_e;

  function automatic logic [AdcChannels-1:0] chan_onehot(input logic [ChanW-1:0] chan);
    logic [AdcChannels-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(AdcChannels); i++) begin
      oh[i] = (chan == ChanW'(i));
    end
    return oh;
  endfunction

  state_e                  state_q, state_d;
  logic [PwrW-1:0]         pwr_cnt_q, pwr_cnt_d;
  logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [IdleW-1:0]        idle_cnt_q, idle_cnt_d;
  logic [ChanW-1:0]        chan_q, chan_d;
  logic [AdcDataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [ChanW-1:0]        rsp_chan_q, rsp_chan_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    adc_pd_q, adc_pd_d;
  logic [AdcChannels-1:0]  sel_q, sel_d;
  logic [7:0]              tmo_tot_q, tmo_tot_d;
  logic                    accept;
  logic                    chan_ok;

  assign req_ready_o = (state_q == StPd) || (state_q == StIdle);
  assign busy_o      = (state_q == StPwrUp) || (state_q == StConv) || (state_q == StResp);
  assign accept      = req_valid_i && req_ready_o;
  assign chan_ok     = (req_chan_i < ChanW'(AdcChannels));

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_chan_o    = rsp_chan_q;
  assign rsp_err_o     = rsp_err_q;
  assign adc_pd_o      = adc_pd_q;
  assign adc_chn_sel_o = sel_q;
  assign timeout_cnt_o = tmo_tot_q;

  // Next-state, counters and response capture.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    idle_cnt_d = idle_cnt_q;
    chan_d     = chan_q;
    rsp_data_d = rsp_data_q;
    rsp_chan_d = rsp_chan_q;
    rsp_err_d  = rsp_err_q;
    tmo_tot_d  = tmo_tot_q;

    case (state_q)
      StPd, StIdle: begin
        if (accept) begin
          chan_d     = req_chan_i;
          idle_cnt_d = '0;
          if (!chan_ok) begin
            // Out-of-range channel answers with an error without touching the ADC.
            state_d    = StResp;
            rsp_data_d = '0;
            rsp_chan_d = req_chan_i;
            rsp_err_d  = 1'b1;
          end else if (state_q == StPd) begin
            state_d   = StPwrUp;
            pwr_cnt_d = '0;
          end else begin
            state_d   = StConv;
            tmo_cnt_d = TmoW'(1);
          end
        end else if ((state_q == StIdle) && lp_en_i) begin
          if (idle_cnt_q == IdleW'(PdDlyCyc - 1)) begin
            state_d    = StPd;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      StPwrUp: begin
        if (pwr_cnt_q == PwrW'(PwrUpCyc - 1)) begin
          state_d   = StConv;
          tmo_cnt_d = TmoW'(1);
        end else begin
          pwr_cnt_d = pwr_cnt_q + PwrW'(1);
        end
      end
      StConv: begin
        if (adc_data_valid_i) begin
          state_d    = StResp;
          rsp_data_d = adc_data_i;
          rsp_chan_d = chan_q;
          rsp_err_d  = 1'b0;
        end else if (tmo_cnt_q == TmoW'(TimeoutCyc)) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_chan_d = chan_q;
          rsp_err_d  = 1'b1;
          if (tmo_tot_q != 8'hFF) begin
            tmo_tot_d = tmo_tot_q + 8'd1;
          end else begin
            tmo_tot_d = tmo_tot_q;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d    = adc_pd_q ? StPd : StIdle;
          idle_cnt_d = '0;
        end else begin
          state_d = StResp;
        end
      end
      default: begin
        state_d = StPd;
      end
    endcase
  end

  // Registered ADC and response outputs derived from the upcoming state.
  always_comb begin
    adc_pd_d    = adc_pd_q;
    sel_d       = '0;
    rsp_valid_d = (state_d == StResp);
    case (state_d)
      StPd:    adc_pd_d = 1'b1;
      StPwrUp: adc_pd_d = 1'b0;
      StIdle:  adc_pd_d = 1'b0;
      StConv: begin
        adc_pd_d = 1'b0;
        sel_d    = chan_onehot(chan_d);
      end
      StResp:  adc_pd_d = adc_pd_q;
      default: adc_pd_d = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StPd;
      pwr_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      chan_q      <= '0;
      rsp_data_q  <= '0;
      rsp_chan_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      adc_pd_q    <= 1'b1;
      sel_q       <= '0;
      tmo_tot_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      chan_q      <= chan_d;
      rsp_data_q  <= rsp_data_d;
      rsp_chan_q  <= rsp_chan_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      adc_pd_q    <= adc_pd_d;
      sel_q       <= sel_d;
      tmo_tot_q   <= tmo_tot_d;
    end
  end

endmodule

// File: doc/ast_adc_seq.md
Name: ast_adc_seq

Overview:
- Conversion sequencer for the AST ADC (adc_ast_req_t / adc_ast_rsp_t interface).
- Accepts single-channel conversion requests from one client and drives ADC power-down and the one-hot channel select.
- Manages power-up settling, captures the result on data_valid, returns the result over a valid/ready response channel, and flags a timeout when the ADC never answers.
- Optionally powers the ADC back down after a programmable idle period.

Parameters:
- AdcChannels, 2, number of ADC channels (matches ast_pkg::AdcChannels).
- AdcDataWidth, 10, result width (matches ast_pkg::AdcDataWidth).
- PwrUpCyc, 8, cycles pd is held low before the first channel select after power-up; minimum 1.
- TimeoutCyc, 64, maximum cycles in CONV waiting for data_valid; minimum 1.
- PdDlyCyc, 16, consecutive idle cycles before auto power-down; minimum 1.
- ChanW (localparam), $clog2(AdcChannels)+1, request channel index width; the extra bit allows out-of-range indices.

Ports:
- clk_i  in  1  clock; one clock; reset is asynchronous and active-high.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  conversion request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_chan_i  in  ChanW  requested channel index.
- rsp_valid_o  out  1  response valid; held until accepted.
- rsp_ready_i  in  1  client accepts the response.
- rsp_data_o  out  AdcDataWidth  conversion result.
- rsp_chan_o  out  ChanW  channel index of this response.
- rsp_err_o  out  1  timeout or invalid channel.
- lp_en_i  in  1  enable auto power-down when idle.
- adc_pd_o  out  1  ADC power-down (adc_ast_req_t.pd).
- adc_chn_sel_o  out  AdcChannels  one-hot channel select (adc_ast_req_t.channel_sel).
- adc_data_i  in  AdcDataWidth  ADC result (adc_ast_rsp_t.data).
- adc_data_valid_i  in  1  ADC result valid (adc_ast_rsp_t.data_valid).
- busy_o  out  1  state is PWRUP, CONV or RESP.
- timeout_cnt_o  out  8  saturating count of timeouts.

Behaviour:
- Reset values: state=PD, adc_pd_o=1, adc_chn_sel_o=0, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_chan_o=0, rsp_err_o=0, busy_o=0, timeout_cnt_o=0, all internal counters=0.
- Reset is asynchronous at any time, including mid-conversion: the block returns to PD immediately and any pending response is dropped.
- Outputs adc_pd_o, adc_chn_sel_o and all rsp_* outputs are registered.
- Accept condition: req_valid_i && req_ready_o. req_ready_o=1 only in PD and IDLE. On accept, req_chan_i is latched.
- Invalid channel (req_chan_i >= AdcChannels): go directly to RESP with rsp_err_o=1 and rsp_data_o=0. The ADC is not touched; pd stays at its current value.
- State PD: adc_pd_o=1. A valid-channel accept moves to PWRUP.
- State PWRUP: adc_pd_o=0, sel=0 for exactly PwrUpCyc cycles, then CONV.
- State IDLE: adc_pd_o=0, sel=0.
  - A valid-channel accept moves to CONV on the next cycle.
  - If lp_en_i=1, idle_cnt increments each cycle; when it reaches PdDlyCyc, go to PD.
  - idle_cnt clears when lp_en_i=0, on accept, and on IDLE entry.
  - An accept in the expiry cycle wins over power-down.
- State CONV: adc_chn_sel_o = one-hot of the latched channel; tmo_cnt counts cycles from CONV entry, with the entry cycle counted as 1.
  - adc_data_valid_i=1: capture adc_data_i, set rsp_err_o=0, go to RESP.
  - Otherwise, when tmo_cnt reaches TimeoutCyc: set rsp_err_o=1, rsp_data_o=0, timeout_cnt_o += 1 (saturating at 255), go to RESP.
  - data_valid in the expiry cycle wins over timeout.
- State RESP: sel=0, rsp_valid_o=1, with rsp_data_o, rsp_chan_o and rsp_err_o stable.
  - On rsp_ready_i go to IDLE; if pd=1 (invalid request from PD), go to PD instead.
  - sel=0 in RESP guarantees at least one deselect cycle between conversions.
- adc_data_valid_i outside CONV is ignored.
- Latency from PD: accept at cycle 0, pd falls at cycle 1, sel asserts at cycle 1+PwrUpCyc.
- Latency from IDLE: sel asserts at cycle 1.
- rsp_valid_o rises one cycle after the capturing data_valid.

Test Plan:
- Reset, then request chan 1 with ADC data_valid 5 cycles after sel and data 10'h2A5: pd falls at cycle 1; sel=2'b10 at cycle 9; rsp_valid=1 with data 10'h2A5, chan 1, err 0; back to IDLE after rsp_ready.
- From IDLE, request chan 0 with rsp_ready held low for 10 cycles: sel=2'b01 at cycle 1; rsp stays valid and stable for 10 cycles; no new request is accepted (req_ready=0).
- ADC silent with TimeoutCyc=64: rsp_err=1 and data=0 after exactly 64 CONV cycles; timeout_cnt_o=1; 300 consecutive timeouts give timeout_cnt_o=255.
- Request chan 2: immediate err response; adc_pd_o stays 1; sel never asserts.
- lp_en_i=1 in IDLE with no requests: adc_pd_o=1 after 16 cycles. A request arriving exactly in cycle 16 is accepted, stays powered up, and asserts sel next cycle.
- Assert rst_i mid-CONV: outputs return to reset values asynchronously. A data_valid arriving on the expiry cycle yields data, not an error.
